// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives a 5-bit word PC into instruction memory, buffers the
// returned words in a small prefetch FIFO and hands them to decode over valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [4:0]  RESET_PC  = 5'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  imem_address,
  output logic        imem_rd,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [4:0]  redirect_address,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [4:0]  inst_pc,
  input  logic        inst_ready,
  output logic        halted
);

  localparam logic [2:0] DepthC  = 3'(DEPTH);
  localparam logic [1:0] LastIdx = 2'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      r_state, w_state_d;
  logic [4:0]  r_pc, w_pc_d;
  logic [2:0]  r_count, w_count_d;
  logic [1:0]  r_wr_ptr, w_wr_ptr_d;
  logic [1:0]  r_rd_ptr, w_rd_ptr_d;

  // Storage is always four slots so the 2-bit pointers index it exactly; only DEPTH are used.
  logic [31:0] r_fifo_data [4];
  logic [4:0]  r_fifo_pc   [4];

  logic w_fetch;
  logic w_is_halt;
  logic w_push;
  logic w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    return (ptr == LastIdx) ? 2'd0 : ptr + 2'd1;
  endfunction

  assign w_fetch   = (r_state == StRun) && (r_count < DepthC) && !redirect_valid;
  assign w_is_halt = (imem_instruction == HALT_WORD);
  assign w_push    = w_fetch && !w_is_halt;
  assign w_pop     = (r_count != 3'd0) && inst_ready && !redirect_valid;

  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_count_d  = r_count;
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;

    if (redirect_valid) begin
      // Redirect wins over any same-cycle push/pop and flushes the FIFO.
      w_state_d  = StRun;
      w_pc_d     = redirect_address;
      w_count_d  = 3'd0;
      w_wr_ptr_d = 2'd0;
      w_rd_ptr_d = 2'd0;
    end else begin
      unique case (r_state)
        StIdle:  w_state_d = StRun;
        StRun:   if (w_fetch && w_is_halt) w_state_d = StHalt;
        StHalt:  w_state_d = StHalt;
        default: w_state_d = StIdle;
      endcase

      if (w_push) begin
        w_wr_ptr_d = next_ptr(r_wr_ptr);
        w_pc_d     = r_pc + 5'd1;
      end
      if (w_pop) begin
        w_rd_ptr_d = next_ptr(r_rd_ptr);
      end

      unique case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + 3'd1;
        2'b01:   w_count_d = r_count - 3'd1;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_pc     <= RESET_PC;
      r_count  <= 3'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_count  <= w_count_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo_data[i] <= 32'd0;
        r_fifo_pc[i]   <= 5'd0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_instruction;
      r_fifo_pc[r_wr_ptr]   <= r_pc;
    end
  end

  assign imem_address = r_pc;
  assign imem_rd      = w_fetch;
  assign inst_valid   = (r_count != 3'd0);
  assign inst_data    = inst_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign inst_pc      = inst_valid ? r_fifo_pc[r_rd_ptr] : 5'd0;
  assign halted       = (r_state == StHalt);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory read interface.
- Keeps a 5-bit word program counter (PC) and drives address and rd into instruction_memory.
- Captures the returned 32-bit word into a small prefetch FIFO and presents it to decode with a valid/ready handshake.
- Supports branch redirect (flush and reload PC) and a halt word that stops fetching.

Parameters:
- DEPTH, 2, prefetch FIFO entries (1..4).
- RESET_PC, 5'd0, PC value loaded on reset.
- HALT_WORD, 32'hFFFFFFFF, fetched word that stops fetching; it is never enqueued.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_address  output  5  word address to instruction_memory; always equals PC.
- imem_rd  output  1  read strobe to instruction_memory; combinational.
- imem_instruction  input  32  instruction_memory read data; combinational in the same cycle as imem_rd.
- redirect_valid  input  1  branch/jump redirect request.
- redirect_address  input  5  new PC on redirect.
- inst_valid  output  1  FIFO head valid.
- inst_data  output  32  FIFO head instruction; 0 when empty.
- inst_pc  output  5  address of FIFO head; 0 when empty.
- inst_ready  input  1  decode accepts head.
- halted  output  1  high in HALT state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: PC=RESET_PC, count=0, state=IDLE, FIFO pointers=0. imem_rd=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0.
- Reset asserted mid-operation discards FIFO contents and any in-flight fetch immediately.
- States:
  - IDLE: exactly one cycle after reset deassert, then RUN.
  - RUN: normal fetching.
  - HALT: no fetching; left only by redirect.
- Fetch condition: imem_rd = (state==RUN) && (count<DEPTH) && !redirect_valid.
  - A pop in the same cycle does not enable the fetch; the freed slot is used next cycle.
- Fetch completion: at the rising edge where imem_rd=1, the fetched word is handled as follows.
  - If imem_instruction != HALT_WORD: push {imem_instruction, PC}, then PC <= PC+1 modulo 32 (31 wraps to 0).
  - If imem_instruction == HALT_WORD: no push, PC holds, state <= HALT.
- Latency: a word fetched in cycle N is visible on inst_valid/inst_data in cycle N+1. Throughput is 1 word/cycle while decode keeps up.
- Pop: happens when inst_valid && inst_ready at the rising edge. The head advances.
- Simultaneous push and pop leaves count unchanged; both happen.
- inst_valid = (count!=0). The head holds stable while inst_valid && !inst_ready.
- Redirect: when redirect_valid=1 at the rising edge:
  - count <= 0 and PC <= redirect_address.
  - State <= RUN, from RUN or HALT. A redirect in IDLE also goes to RUN.
  - Redirect has priority over push and pop. A same-cycle handshake counts as accepted by decode, but the FIFO is still cleared.
  - Fetching resumes the cycle after redirect, at redirect_address.
- In HALT the FIFO keeps draining normally. halted=1 and imem_rd=0.
- FIFO: circular buffer with read/write pointers modulo DEPTH and count in 0..DEPTH.
  - Never overflows, because no fetch occurs when full.
  - Never underflows, because no pop occurs when empty.

Test Plan:
1. Reset, then memory words[k]=32'h1000_0000+k, inst_ready=1 held:
   - imem_rd=0 in IDLE.
   - First inst_valid two cycles after reset release, inst_pc=0, inst_data=32'h10000000.
   - inst_pc then increments by 1 every cycle.
   - Sequence checked against a reference queue.
2. Backpressure, inst_ready=0 with DEPTH=2:
   - Exactly 2 fetches, then imem_rd=0.
   - Head stays inst_pc=0 / 32'h10000000.
   - After inst_ready=1, order is 0,1,2,... with no loss or duplication.
3. Redirect, with FIFO holding PCs 4,5, redirect_valid=1 and redirect_address=5'd20 for one cycle:
   - Next cycle inst_valid=0 and imem_address=20.
   - Following cycle inst_pc=20, inst_data=32'h10000014.
4. Wrap-around, redirect to 30:
   - Delivered PCs are 30,31,0,1.
   - imem_address wraps 31 to 0.
5. Halt, word[7]=HALT_WORD, start from 0:
   - PCs 0..6 delivered.
   - imem_rd low after the fetch at PC 7; halted=1; imem_address stays 7; 32'hFFFFFFFF never appears.
   - Redirect to 2 clears halted and resumes at PC 2.
6. Reset mid-stream:
   - Assert rst_n=0 asynchronously between edges with count=2.
   - Outputs go to reset values immediately.
   - After release, fetch restarts at RESET_PC.
